// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths, register count and index/data types for the register file.
package register_file_pkg;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int NUM_REGS = 2 ** RF_ADDR_WIDTH;
  typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;
  typedef logic [RF_ADDR_WIDTH-1:0] reg_idx_t;
  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/register_file_read_port.sv
// register_file_read_port: combinational index-to-data mux with x0 forced to zero and optional forwarded data.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                    idx,
  input  logic                                     fwd,
  input  logic [DATA_WIDTH-1:0]                    fwd_data,
  output logic [DATA_WIDTH-1:0]                    data
);
  always_comb data = (idx == ADDR_WIDTH'(ZERO_REG)) ? '0 : fwd ? fwd_data : regs[idx];
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 register file, one sync write port, two combinational read ports, x0 hardwired to zero.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] write,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] read1,
  output logic [DATA_WIDTH-1:0] read2
);
  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs;
  logic wr_ok, fwd1, fwd2;
  assign wr_ok = enable && (rd != ADDR_WIDTH'(ZERO_REG));
  always_ff @(posedge clk)
    if (!reset) regs <= '0;
    else if (wr_ok) regs[rd] <= write;
`ifdef REGISTER_FILE_BYPASS_EN
  assign fwd1 = wr_ok && reset && (rd == rs1);
  assign fwd2 = wr_ok && reset && (rd == rs2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  register_file_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rp1 (
    .regs(regs), .idx(rs1), .fwd(fwd1), .fwd_data(write), .data(read1)
  );
  register_file_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rp2 (
    .regs(regs), .idx(rs2), .fwd(fwd2), .fwd_data(write), .data(read2)
  );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard-driven self-checking bench for register_file.
module tb_register_file;
  import register_file_pkg::*;
  logic clk, reset, enable;
  reg_data_t write, read1, read2;
  reg_idx_t rd, rs1, rs2;
  reg_data_t mdl [NUM_REGS];
  reg_data_t exp_q[$];
  int passed, total;

  register_file dut (
    .clk(clk), .reset(reset), .enable(enable), .write(write),
    .rd(rd), .rs1(rs1), .rs2(rs2), .read1(read1), .read2(read2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input reg_data_t got, input reg_data_t exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  function automatic reg_data_t model_read(input reg_idx_t a);
    if (a == 0) return '0;
`ifdef REGISTER_FILE_BYPASS_EN
    if (enable && reset && rd == a) return write;
`endif
    return mdl[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) foreach (mdl[i]) mdl[i] = '0;
    else if (enable && rd != 0) mdl[rd] = write;
    @(negedge clk);
  endtask

  task automatic rd2(input string tag, input reg_idx_t a, input reg_idx_t b);
    rs1 = a;
    rs2 = b;
    exp_q.push_back(model_read(a));
    exp_q.push_back(model_read(b));
    #1;
    check({tag, "/read1"}, read1, exp_q.pop_front());
    check({tag, "/read2"}, read2, exp_q.pop_front());
  endtask

  task automatic wr(input reg_idx_t a, input reg_data_t d);
    enable = 1'b1;
    rd = a;
    write = d;
    tick();
    enable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b0;
    enable = 1'b0;
    write = '0;
    rd = '0;
    rs1 = '0;
    rs2 = '0;
    foreach (mdl[i]) mdl[i] = 'x;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < NUM_REGS; i += 4) rd2("init_zero", reg_idx_t'(i), reg_idx_t'(NUM_REGS - 1 - i));
    for (int i = 1; i < NUM_REGS; i++) wr(reg_idx_t'(i), $urandom() | 32'h1);
    rd2("fill", 1, 31);
    rd2("fill", 16, 17);
    do_reset();
    for (int i = 0; i < NUM_REGS; i++) rd2("reset_clear", reg_idx_t'(i), reg_idx_t'(i));
    wr(5, 32'hDEADBEEF);
    rd2("basic_x5", 5, 5);
    check("basic_x5_const", read1, 32'hDEADBEEF);
    wr(0, 32'h12345678);
    rd2("x0_protect", 0, 0);
    check("x0_const", read1, 32'h0);
    wr(7, 32'h11111111);
    rd = 7;
    write = 32'h22222222;
    tick();
    rd2("enable_gate", 7, 7);
    check("enable_gate_const", read2, 32'h11111111);
    wr(3, 32'hAAAA0003);
    wr(4, 32'h55550004);
    rd2("dual_read", 3, 4);
    check("dual_x3_const", read1, 32'hAAAA0003);
    check("dual_x4_const", read2, 32'h55550004);
    reset = 1'b0;
    enable = 1'b1;
    rd = 3;
    write = 32'hFFFF0333;
    tick();
    enable = 1'b0;
    reset = 1'b1;
    rd2("reset_priority", 3, 4);
    check("reset_priority_const", read1, 32'h0);
    wr(10, 32'h0A0A0A0A);
    rd2("first_after_reset", 10, 3);
    enable = 1'b1;
    rd = 9;
    write = 32'hCAFEF00D;
    rd2("same_cycle", 9, 9);
`ifdef REGISTER_FILE_BYPASS_EN
    check("same_cycle_const", read1, 32'hCAFEF00D);
`else
    check("same_cycle_const", read1, 32'h0);
`endif
    rd2("same_cycle_x0", 0, 10);
    tick();
    enable = 1'b0;
    rd2("after_edge", 9, 9);
    check("after_edge_const", read2, 32'hCAFEF00D);
    for (int i = 0; i < 20; i++) begin
      enable = 1'($urandom_range(0, 1));
      rd = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
      write = $urandom();
      rd2("rand_pre", reg_idx_t'($urandom_range(0, NUM_REGS - 1)), rd);
      tick();
      rd2("rand_post", rd, reg_idx_t'($urandom_range(0, NUM_REGS - 1)));
    end
    enable = 1'b0;
    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
